// File: rtl/axi4_stream_pkg.sv
// Shared defaults and the stored entry layout for the AXI4-Stream FIFO.
package axi4_stream_pkg;

   localparam int unsigned DEF_DATA_SIZE = 8;
   localparam int unsigned DEF_DEPTH     = 16;

   typedef struct packed {
      logic                     last;
      logic [DEF_DATA_SIZE-1:0] data;
   } entry_t;

   function automatic bit is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/axi4_stream_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module axi4_stream_fifo_mem #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_stream_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with registered handshake and fill-level flags.
module axi4_stream_fifo
   import axi4_stream_pkg::*;
#(
   parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned AF_LEVEL  = DEPTH - 2,
   parameter int unsigned AE_LEVEL  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [DATA_SIZE-1:0]       s_data,
   input  logic                       s_last,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [DATA_SIZE-1:0]       m_data,
   output logic                       m_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned EW = DATA_SIZE + 1;

   if (DATA_SIZE < 1) begin : g_bad_width
      $error("axi4_stream_fifo: DATA_SIZE must be >= 1");
   end
   if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
      $error("axi4_stream_fifo: DEPTH must be a power of two >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("axi4_stream_fifo: AF_LEVEL out of range 1..DEPTH");
   end
   if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("axi4_stream_fifo: AE_LEVEL out of range 0..DEPTH-1");
   end

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_nxt;
   logic          wr_en;
   logic          rd_en;
   logic [EW-1:0] rd_entry;

   // Handshakes depend only on registered ready/valid, never combinationally on the peer.
   assign wr_en = s_valid & s_ready;
   assign rd_en = m_ready & m_valid;

   always_comb begin
      level_nxt = level;
      case ({wr_en, rd_en})
         2'b10:   level_nxt = level + LW'(1);
         2'b01:   level_nxt = level - LW'(1);
         default: level_nxt = level;
      endcase
   end

   // Flags are registered from the next level so they line up with level itself.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         empty        <= 1'b1;
         m_valid      <= 1'b0;
         full         <= 1'b0;
         s_ready      <= 1'b1;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         level        <= level_nxt;
         empty        <= (level_nxt == '0);
         m_valid      <= (level_nxt != '0);
         full         <= (level_nxt == LW'(DEPTH));
         s_ready      <= (level_nxt != LW'(DEPTH));
         almost_empty <= (level_nxt <= LW'(AE_LEVEL));
         almost_full  <= (level_nxt >= LW'(AF_LEVEL));
      end
   end

   axi4_stream_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata ({s_last, s_data}),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   assign {m_last, m_data} = rd_entry;

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Bench for axi4_stream_fifo: directed scenarios plus random traffic against a queue model.
module tb_axi4_stream_fifo;
   import axi4_stream_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int AE    = 1;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_valid;
   logic          m_ready;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [2:0]    level;

   int errors = 0;
   int checks = 0;
   entry_t model[$];
   entry_t rx[$];

   axi4_stream_fifo #(
      .DATA_SIZE (DW),
      .DEPTH     (DEPTH),
      .AF_LEVEL  (AF),
      .AE_LEVEL  (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .level        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare every status output and the head word against the model queue.
   task automatic check_state();
      int n;
      n = model.size();
      chk("level",        32'(level),        32'(n));
      chk("empty",        32'(empty),        32'(n == 0));
      chk("full",         32'(full),         32'(n == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
      chk("almost_full",  32'(almost_full),  32'(n >= AF));
      chk("s_ready",      32'(s_ready),      32'(n != DEPTH));
      chk("m_valid",      32'(m_valid),      32'(n != 0));
      if (n > 0) begin
         chk("m_data", 32'(m_data), 32'(model[0].data));
         chk("m_last", 32'(m_last), 32'(model[0].last));
      end
   endtask

   // One clock: predict handshakes from the model, advance it, then check after the edge.
   task automatic step();
      bit     wr;
      bit     rd;
      entry_t e;
      entry_t o;
      wr = s_valid && (model.size() < DEPTH);
      rd = m_ready && (model.size() > 0);
      e.last = s_last;
      e.data = s_data;
      if (m_valid === 1'b1 && m_ready) begin
         o.last = m_last;
         o.data = m_data;
         rx.push_back(o);
      end
      @(posedge clk);
      if (rst || flush) begin
         model.delete();
      end else begin
         if (rd) void'(model.pop_front());
         if (wr) model.push_back(e);
      end
      @(negedge clk);
      check_state();
   endtask

   initial begin
      int sent;
      rst = 1'b1; flush = 1'b0; s_data = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_m_valid", 32'(m_valid), 32'd0);

      // Single write shows up on the next cycle.
      s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
      step();
      s_valid = 1'b0;
      chk("w1_m_valid", 32'(m_valid), 32'd1);
      chk("w1_m_data", 32'(m_data), 32'h11);
      chk("w1_level", 32'(level), 32'd1);
      chk("w1_empty", 32'(empty), 32'd0);
      chk("w1_almost_empty", 32'(almost_empty), 32'd1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("w1_drained", 32'(empty), 32'd1);

      // Fill to full, refuse the fifth write, drain in order.
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 8'(8'hA0 + i);
         step();
         chk("fill_level", 32'(level), 32'(i + 1));
         if (i == 2) chk("af_at_3", 32'(almost_full), 32'd1);
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_s_ready", 32'(s_ready), 32'd0);
      s_data = 8'hA4;
      step();
      chk("fifth_refused", 32'(level), 32'd4);
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 32'(m_data), 32'(8'hA0 + i));
         step();
      end
      m_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);

      // Full with read and write: only the read happens; then both happen.
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = 8'(8'hB0 + i);
         step();
      end
      s_data = 8'hC0; m_ready = 1'b1;
      step();
      chk("full_rw_level", 32'(level), 32'd3);
      chk("full_rw_head", 32'(m_data), 32'hB1);
      s_data = 8'hC1;
      step();
      chk("both_rw_level", 32'(level), 32'd3);
      chk("both_rw_head", 32'(m_data), 32'hB2);
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      m_ready = 1'b0;
      chk("rw_drained", 32'(empty), 32'd1);

      // Ten-word stream with last on the 5th and 10th, random back-pressure.
      rx.delete();
      sent = 0;
      for (int cyc = 0; cyc < 300 && rx.size() < 10; cyc++) begin
         s_valid = (sent < 10);
         s_data  = 8'(8'h50 + sent);
         s_last  = (sent == 4 || sent == 9);
         m_ready = 1'($urandom_range(0, 1));
         if (s_valid && model.size() < DEPTH) sent++;
         step();
      end
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      chk("stream_count", 32'(rx.size()), 32'd10);
      for (int i = 0; i < rx.size(); i++) begin
         chk("stream_data", 32'(rx[i].data), 32'(8'h50 + i));
         chk("stream_last", 32'(rx[i].last), 32'(i == 4 || i == 9));
      end

      // Flush with a same-cycle write and read pending.
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1; s_data = 8'(8'hD0 + i);
         step();
      end
      chk("pre_flush_level", 32'(level), 32'd2);
      flush = 1'b1; m_ready = 1'b1;
      step();
      flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_m_valid", 32'(m_valid), 32'd0);

      // Reset mid-stream behaves the same.
      for (int i = 0; i < 2; i++) begin
         s_valid = 1'b1; s_data = 8'(8'hE0 + i);
         step();
      end
      rst = 1'b1; m_ready = 1'b1;
      step();
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      chk("rst_mid_level", 32'(level), 32'd0);
      chk("rst_mid_empty", 32'(empty), 32'd1);
      chk("rst_mid_m_valid", 32'(m_valid), 32'd0);

      // Random traffic with occasional flushes.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         s_valid = 1'($urandom_range(0, 1));
         m_ready = 1'($urandom_range(0, 1));
         s_data  = 8'($urandom);
         s_last  = 1'($urandom_range(0, 1));
         flush   = ($urandom_range(0, 199) == 0);
         step();
      end
      flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4_stream_fifo.md
AXI4_STREAM_FIFO -- requirements
Module: axi4_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_SIZE, 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, 16, storage entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, DEPTH-2, fill level at/above which almost_full asserts (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, 2, fill level at/below which almost_empty asserts (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents, rst-equivalent for storage state.
REQ-008 SHALL have port s_data  input  DATA_SIZE  slave payload.
REQ-009 SHALL have port s_last  input  1  slave end-of-packet marker.
REQ-010 SHALL have port s_valid  input  1  slave valid.
REQ-011 SHALL have port s_ready  output  1  slave ready.
REQ-012 SHALL have port m_data  output  DATA_SIZE  master payload.
REQ-013 SHALL have port m_last  output  1  master end-of-packet marker.
REQ-014 SHALL have port m_valid  output  1  master valid.
REQ-015 SHALL have port m_ready  input  1  master ready.
REQ-016 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-017 SHALL have port level  output  $clog2(DEPTH+1)  current entry count.

Function
REQ-018 Write handshake SHALL occur on a cycle with s_valid && s_ready; read handshake on m_valid && m_ready.
REQ-019 s_ready SHALL equal !full; m_valid SHALL equal !empty; both registered-state-derived, no combinational path from s_valid or m_ready.
REQ-020 Storage SHALL hold {s_last, s_data} per entry; m_data/m_last SHALL present the oldest entry (first-word-fall-through).
REQ-021 Latency: word written at edge N SHALL be visible on m_data with m_valid=1 after edge N (cycle N+1); no empty-bypass path.
REQ-022 Once m_valid=1, m_data/m_last SHALL stay stable until the read handshake.
REQ-023 Write/read pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; level SHALL track writes minus reads, range 0..DEPTH.
REQ-024 Simultaneous read and write (neither empty nor full) SHALL leave level unchanged and advance both pointers.
REQ-025 When full, writes SHALL be refused (s_ready=0) even if a read occurs that cycle; when empty, no read occurs.
REQ-026 full SHALL be 1 iff level==DEPTH; empty iff level==0; almost_full iff level>=AF_LEVEL; almost_empty iff level<=AE_LEVEL.
REQ-027 flush SHALL, at the next edge, zero pointers and level, ignoring any same-cycle handshake; flush has priority below rst only.
REQ-028 Overflow/underflow SHALL be impossible by construction; no data SHALL be dropped or duplicated.

Reset
REQ-029 On rst=1 at an edge: pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_LEVEL==0 disallowed), s_ready=1, m_valid=0.
REQ-030 m_data/m_last SHALL be don't-care while m_valid=0; storage array SHALL NOT be reset.
REQ-031 rst asserted mid-transfer SHALL discard all contents; in-flight handshakes on that cycle SHALL have no effect.

Structure
REQ-032 Shared package axi4_stream_pkg SHALL hold default DATA_SIZE/DEPTH constants and the packed entry typedef {last, data}.
REQ-033 Storage SHALL be a sub-module axi4_stream_fifo_mem (DEPTH x DATA_SIZE+1, one write port, one asynchronous read port); control/flags in the top.
REQ-034 Elaboration SHALL fail on non-power-of-two DEPTH or AF_LEVEL/AE_LEVEL out of range.

Verification (DATA_SIZE=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 After rst, write 0x11 -> next cycle m_valid=1, m_data=0x11, level=1, empty=0, almost_empty=1.
REQ-036 Write 0xA0..0xA3, m_ready=0 -> full=1, s_ready=0, almost_full=1 at level 3; fifth write refused; drain yields A0,A1,A2,A3 in order.
REQ-037 Fill 4, then s_valid=1 and m_ready=1 for 1 cycle -> only read occurs, level=3; next cycle simultaneous read+write -> level stays 3.
REQ-038 Stream 10 words with s_last on the 5th and 10th, random m_ready -> m_last asserted exactly with 5th and 10th words; pointer wrap exercised.
REQ-039 Level=2, assert flush with s_valid=1 -> next cycle level=0, empty=1, m_valid=0; rst mid-stream gives identical result.
REQ-040 Random s_valid/m_ready 10k cycles vs scoreboard -> zero mismatches, flags consistent with level every cycle.
